// File: rtl/alu_result_retire.sv
// Retire stage for the packed ALU result bus: a small FIFO feeding the register-file write port,
// an architectural status register, and branch-condition evaluation. Optional zero-latency path: ALU_RETIRE_BYPASS_EN.
module alu_result_retire #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [19:0]   in_word,
    input  logic [2:0]    in_rd,
    input  logic          in_setf,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [2:0]    wb_rd,
    output logic [15:0]   wb_data,
    output logic          flag_s,
    output logic          flag_v,
    output logic          flag_z,
    output logic          flag_c,
    input  logic [3:0]    cond,
    output logic          cond_true,
    output logic [AW:0]   count
);

    typedef struct packed {
        logic [19:0] word;
        logic [2:0]  rd;
        logic        setf;
    } entry_t;

    entry_t      mem [DEPTH];
    entry_t      in_entry;
    entry_t      head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        bypass;
    logic        push;
    logic        pop;
    logic        fifo_pop;

    assign in_entry = '{word: in_word, rd: in_rd, setf: in_setf};

    // The extra pointer MSB is a wrap bit, so full and empty are distinguishable without a separate counter.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign in_ready = !full;

`ifdef ALU_RETIRE_BYPASS_EN
    assign bypass = empty && in_valid;
`else
    assign bypass = 1'b0;
`endif

    assign head     = bypass ? in_entry : mem[rd_ptr[AW-1:0]];
    assign wb_valid = !empty || bypass;
    assign wb_rd    = head.rd;
    assign wb_data  = head.word[15:0];

    // A bypassed word that retires in the same cycle never occupies a FIFO slot.
    assign pop      = wb_valid && wb_ready;
    assign push     = in_valid && in_ready && !(bypass && wb_ready);
    assign fifo_pop = pop && !bypass;

    // NOTE: storage carries no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_entry;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            flag_s <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (pop && head.setf) begin
                flag_c <= head.word[19];
                flag_z <= head.word[18];
                flag_v <= head.word[17];
                flag_s <= head.word[16];
            end
        end
    end

    // NOTE: a default ahead of the case keeps this purely combinational for every selector value.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:    cond_true = flag_z;
            4'd1:    cond_true = !flag_z;
            4'd2:    cond_true = flag_s ^ flag_v;
            4'd3:    cond_true = (flag_s ^ flag_v) | flag_z;
            4'd4:    cond_true = !((flag_s ^ flag_v) | flag_z);
            4'd5:    cond_true = !(flag_s ^ flag_v);
            4'd6:    cond_true = flag_c;
            4'd7:    cond_true = !flag_c;
            4'd8:    cond_true = flag_s;
            4'd9:    cond_true = !flag_s;
            4'd10:   cond_true = flag_v;
            4'd11:   cond_true = !flag_v;
            4'd12:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule
